// File: rtl/stream_src_driver.sv
// Burst source for the 32-bit word stream: offers len words (incrementing or LFSR)
// under the rdy handshake, then counts/XORs the sink's done/dout results until complete or timeout.
module stream_src_driver #(
  parameter int DW      = 32,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [DW-1:0]    seed,
  input  logic             mode,
  output logic             wen,
  output logic [DW-1:0]    din,
  input  logic             rdy,
  input  logic [DW-1:0]    dout,
  input  logic             done,
  output logic             busy,
  output logic [LEN_W-1:0] rx_cnt,
  output logic [DW-1:0]    chksum,
  output logic             complete,
  output logic             timeout_err
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [DW-1:0]    r_word;
  logic [LEN_W-1:0] r_len, r_sent, r_rx_cnt;
  logic [DW-1:0]    r_chksum;
  logic [TW-1:0]    r_to_cnt;
  logic             r_mode, r_timeout_err;

  logic w_active, w_xfer, w_rx, w_quiet, w_tmo, w_last, w_rx_met, w_accept;
  logic [DW-1:0] w_word_nxt, w_seed_ld;

  assign w_active = (r_state == SEND) || (r_state == WAIT);
  assign w_xfer   = (r_state == SEND) && rdy;
  assign w_rx     = w_active && done;
  assign w_quiet  = w_active && !w_xfer && !done;
  assign w_tmo    = w_quiet && (r_to_cnt == TMO_MAX);
  assign w_last   = w_xfer && (r_sent == r_len - LEN_W'(1));
  assign w_rx_met = (r_state == WAIT) && (r_rx_cnt == r_len);
  assign w_accept = (r_state == IDLE) && start;

  // Galois right-shift LFSR (taps 0x80200003) or plain increment
  assign w_word_nxt = r_mode ? ((r_word >> 1) ^ (r_word[0] ? DW'(32'h80200003) : '0))
                             : r_word + DW'(1);
  // An all-zero LFSR state would lock up, so a zero seed starts at 1
  assign w_seed_ld  = (mode && seed == '0) ? DW'(1) : seed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (start) w_state_nxt = (len != '0) ? SEND : DONE;
      SEND: if (w_tmo) w_state_nxt = DONE;
            else if (w_last) w_state_nxt = WAIT;
      WAIT: if (w_rx_met || w_tmo) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word        <= '0;
      r_len         <= '0;
      r_mode        <= 1'b0;
      r_sent        <= '0;
      r_rx_cnt      <= '0;
      r_chksum      <= '0;
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else if (w_accept) begin
      r_len         <= len;
      r_mode        <= mode;
      r_word        <= w_seed_ld;
      r_sent        <= '0;
      r_rx_cnt      <= '0;
      r_chksum      <= '0;
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_sent <= r_sent + LEN_W'(1);
        r_word <= w_word_nxt;
      end
      if (w_rx) begin
        if (r_rx_cnt != '1) r_rx_cnt <= r_rx_cnt + LEN_W'(1);
        r_chksum <= r_chksum ^ dout;
      end
      if (w_xfer || w_rx) r_to_cnt <= '0;
      else if (w_quiet)   r_to_cnt <= r_to_cnt + TW'(1);
      // A burst whose last result lands on the timeout cycle still counts as good
      if (w_tmo && !w_rx_met) r_timeout_err <= 1'b1;
    end
  end

  assign wen         = (r_state == SEND);
  assign din         = r_word;
  assign busy        = (r_state != IDLE);
  assign complete    = (r_state == DONE);
  assign rx_cnt      = r_rx_cnt;
  assign chksum      = r_chksum;
  assign timeout_err = r_timeout_err;
endmodule
